instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory address width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of encoded-word buffer entries (power of 2, at least 2).
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, giving the first write address after start.

Ports:
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a load session.
REQ-007 finish  in  1  one-cycle pulse that ends input acceptance and drains the buffer.
REQ-008 in_valid / in_ready  in / out  1 / 1  field-tuple handshake.
REQ-009 f_cond  in  4  condition field; f_type  in  2  type code.
REQ-010 f_imm_en  in  1  immediate flag; f_set  in  1  set-condition flag.
REQ-011 f_op  in  4  opcode nibble; its bit 0 is the load bit, bit 3 the link bit, and bit 2 the branch-to-link bit.
REQ-012 f_rd, f_rh, f_ro  in  5 each  register indices; f_imm  in  32  signed immediate.
REQ-013 mem_we  out  1  write request; mem_ready  in  1  memory accept.
REQ-014 mem_addr  out  ADDR_W  write address; mem_wdata  out  32  encoded word.
REQ-015 busy  out  1  high in RUN or DRAIN; done  out  1  one-cycle drain-complete pulse.
REQ-016 err  out  1  one-cycle reject pulse; err_cnt  out  8  saturating reject count.
REQ-017 wrapped  out  1  sticky address-wrap flag; words  out  16  saturating count of words written.

Function
REQ-018 Encoding SHALL be [31:28]=f_cond, [27:26]=f_type, [25]=f_imm_en, [24]=f_set, [23:20]=f_op, [19:15]=f_rd, and [14:10]=f_rh.
REQ-019 With f_imm_en=0, the encoder SHALL set [9:5]=f_ro and [4:0]=0.
REQ-020 With f_imm_en=1, the encoder SHALL set [9:0]=f_imm[9:0] and SHALL ignore f_ro.
REQ-021 Encoding SHALL be combinational on the inputs, and the result SHALL be pushed into the FIFO on the accepting edge.
REQ-022 The FSM SHALL have states IDLE, RUN, DRAIN, and reset SHALL enter IDLE.
REQ-023 In IDLE, start SHALL move the FSM to RUN, set mem_addr=BASE_ADDR, and clear words, err_cnt and wrapped.
REQ-024 In IDLE, finish SHALL be ignored.
REQ-025 In RUN, finish SHALL move the FSM to DRAIN, and start SHALL be ignored.
REQ-026 In DRAIN, when the FIFO is empty and no write is in flight, the FSM SHALL move to IDLE and pulse done for 1 cycle.
REQ-027 In DRAIN, start SHALL be ignored.
REQ-028 in_ready SHALL be 1 only when the FSM is in RUN and FIFO count < FIFO_DEPTH (registered count); it SHALL NOT look ahead to a same-cycle pop.
REQ-029 A tuple SHALL be accepted when in_valid and in_ready are both 1.
REQ-030 A tuple with f_imm_en=1 and f_imm outside [-512, 511] (upper 22 bits not equal to the sign of bit 9) SHALL be consumed but not pushed.
REQ-031 A rejected tuple SHALL pulse err for 1 cycle and increment err_cnt, which saturates at 255.
REQ-032 mem_we SHALL equal "FIFO not empty", and mem_wdata SHALL be the FIFO head.
REQ-033 mem_we, mem_addr and mem_wdata SHALL stay stable until mem_ready is 1.
REQ-034 A write completes when mem_we and mem_ready are both 1; on completion the block SHALL pop the FIFO, increment mem_addr, and increment words (saturating at 0xFFFF).
REQ-035 Minimum latency from accept to mem_we=1 SHALL be 1 cycle.
REQ-036 mem_addr SHALL wrap from 2^ADDR_W-1 to 0, and each wrap SHALL set wrapped, which holds until the next start or reset.
REQ-037 With a push and a pop in the same cycle, the FIFO count SHALL be unchanged and order SHALL be preserved.
REQ-038 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-039 finish arriving in the same cycle as an accept SHALL still push that tuple.

Reset
REQ-040 While rst=0, outputs SHALL be: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, err_cnt=0, wrapped=0, words=0.
REQ-041 While rst=0, the FIFO SHALL be empty and the FSM SHALL be in IDLE.
REQ-042 Reset asserted mid-session SHALL discard buffered words with no further mem_we.
REQ-043 After reset, the block SHALL await start.

Verification
REQ-044 Register tuple: start; cond=E, type=0, imm_en=0, set=1, op=4, rd=1, rh=2, ro=3, mem_ready=1 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0xE1408860; words=1.
REQ-045 Immediate tuple: cond=0, type=1, imm_en=1, set=0, op=1, rd=5, rh=0, imm=-1 -> mem_wdata=0x061283FF.
REQ-046 Range reject: imm_en=1, imm=512 -> no mem_we, err pulse, err_cnt=1; then imm=-512 -> accepted, [9:0]=0x200.
REQ-047 Backpressure: mem_ready=0, stream 6 tuples -> in_ready drops after 4 accepts; mem_addr/mem_wdata stable; after release, 4 words at addresses 0..3 in order.
REQ-048 Wrap/drain: ADDR_W=2, 5 tuples, finish -> addresses 0,1,2,3,0; wrapped=1; done pulses once after the 5th write; busy=0.
REQ-049 Reset mid-session: assert rst with 3 buffered words -> mem_we=0 immediately; after release, FSM in IDLE and in_ready=0 until start.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction-field encoder: packs accepted field tuples into 32-bit words,
// buffers them in a small FIFO and streams them to instruction memory.
module instr_encoder #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        f_cond,
   input  logic [1:0]        f_type,
   input  logic              f_imm_en,
   input  logic              f_set,
   input  logic [3:0]        f_op,
   input  logic [4:0]        f_rd,
   input  logic [4:0]        f_rh,
   input  logic [4:0]        f_ro,
   input  logic [31:0]       f_imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        err_cnt,
   output logic              wrapped,
   output logic [15:0]       words
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      enc_word;
   logic             imm_ok, accept, push, reject, pop, sess_start;

   // Immediate form carries imm[9:0]; register form carries ro in [9:5].
   assign enc_word = {f_cond, f_type, f_imm_en, f_set, f_op, f_rd, f_rh,
                      f_imm_en ? f_imm[9:0] : {f_ro, 5'd0}};

   // The immediate fits in 10 signed bits only if bits 31..9 all agree.
   assign imm_ok = !f_imm_en || (&f_imm[31:9]) || !(|f_imm[31:9]);

   assign in_ready   = (state == RUN) && (count < CNT_W'(FIFO_DEPTH));
   assign accept     = in_valid && in_ready;
   assign push       = accept && imm_ok;
   assign reject     = accept && !imm_ok;
   assign mem_we     = (count != '0);
   assign mem_wdata  = mem_we ? fifo_mem[rd_ptr] : '0;
   assign pop        = mem_we && mem_ready;
   assign sess_start = (state == IDLE) && start;
   assign busy       = (state != IDLE);

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (finish) state_nxt = DRAIN;
         DRAIN: begin
            if (count == '0) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: FIFO storage is not reset; the head is only visible while mem_we is high.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= enc_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr <= BASE;
         wrapped  <= 1'b0;
         words    <= '0;
         err      <= 1'b0;
         err_cnt  <= '0;
      end else begin
         err <= reject;
         if (sess_start) begin
            mem_addr <= BASE;
            wrapped  <= 1'b0;
            words    <= '0;
            err_cnt  <= '0;
         end else begin
            if (pop) begin
               mem_addr <= mem_addr + ADDR_W'(1);
               if (mem_addr == '1)       wrapped <= 1'b1;
               if (words != 16'hFFFF)    words   <= words + 16'd1;
            end
            if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a queue-based model checked every cycle against a
// default-width instance and a 2-bit-address instance, plus literal spot checks.
module tb_instr_encoder;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0]  cond;
      logic [1:0]  typ;
      logic        imm_en;
      logic        set;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rh;
      logic [4:0]  ro;
      logic [31:0] imm;
   } tuple_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start, finish, in_valid, mem_ready;
   tuple_t cur;

   logic        in_ready8, mem_we8, busy8, done8, err8, wrapped8;
   logic [7:0]  mem_addr8, err_cnt8;
   logic [31:0] mem_wdata8;
   logic [15:0] words8;
   logic        in_ready2, mem_we2, busy2, done2, err2, wrapped2;
   logic [1:0]  mem_addr2;
   logic [7:0]  err_cnt2;
   logic [31:0] mem_wdata2;
   logic [15:0] words2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_encoder dut8 (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready8),
      .f_cond(cur.cond), .f_type(cur.typ), .f_imm_en(cur.imm_en), .f_set(cur.set),
      .f_op(cur.op), .f_rd(cur.rd), .f_rh(cur.rh), .f_ro(cur.ro), .f_imm(cur.imm),
      .mem_we(mem_we8), .mem_ready(mem_ready), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
      .busy(busy8), .done(done8), .err(err8), .err_cnt(err_cnt8),
      .wrapped(wrapped8), .words(words8)
   );

   instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) dut2 (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready2),
      .f_cond(cur.cond), .f_type(cur.typ), .f_imm_en(cur.imm_en), .f_set(cur.set),
      .f_op(cur.op), .f_rd(cur.rd), .f_rh(cur.rh), .f_ro(cur.ro), .f_imm(cur.imm),
      .mem_we(mem_we2), .mem_ready(mem_ready), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .busy(busy2), .done(done2), .err(err2), .err_cnt(err_cnt2),
      .wrapped(wrapped2), .words(words2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] model_word(input tuple_t t);
      longint w;
      w = longint'(t.cond) * 268435456 + longint'(t.typ) * 67108864
        + longint'(t.imm_en) * 33554432 + longint'(t.set) * 16777216
        + longint'(t.op) * 1048576 + longint'(t.rd) * 32768 + longint'(t.rh) * 1024;
      if (t.imm_en) w = w + longint'(t.imm % 1024);
      else          w = w + longint'(t.ro) * 32;
      return w[31:0];
   endfunction

   function automatic bit model_in_range(input tuple_t t);
      int v;
      v = $signed(t.imm);
      return !t.imm_en || (v >= -512 && v <= 511);
   endfunction

   bit          m_run = 0, m_drain = 0, m_err = 0;
   logic [31:0] q[$];
   int          m_n = 0, m_errs = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run = 0; m_drain = 0; m_err = 0; m_n = 0; m_errs = 0;
         q.delete();
      end else begin
         bit rdy, empty0;
         rdy    = m_run && q.size() < DEPTH;
         empty0 = (q.size() == 0);
         m_err  = 0;
         if (!empty0 && mem_ready) begin
            void'(q.pop_front());
            m_n++;
         end
         if (in_valid && rdy) begin
            if (model_in_range(cur)) q.push_back(model_word(cur));
            else begin
               m_err = 1;
               if (m_errs < 255) m_errs++;
            end
         end
         if (!m_run && !m_drain) begin
            if (start) begin m_run = 1; m_n = 0; m_errs = 0; end
         end else if (m_run) begin
            if (finish) begin m_run = 0; m_drain = 1; end
         end else if (empty0) begin
            m_drain = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [31:0] head;
      head = (q.size() != 0) ? q[0] : 32'd0;
      check("in_ready8",  {31'd0, in_ready8},  {31'd0, m_run && q.size() < DEPTH});
      check("in_ready2",  {31'd0, in_ready2},  {31'd0, m_run && q.size() < DEPTH});
      check("mem_we8",    {31'd0, mem_we8},    {31'd0, q.size() != 0});
      check("mem_we2",    {31'd0, mem_we2},    {31'd0, q.size() != 0});
      check("mem_wdata8", mem_wdata8, head);
      check("mem_wdata2", mem_wdata2, head);
      check("mem_addr8",  {24'd0, mem_addr8},  m_n % 256);
      check("mem_addr2",  {30'd0, mem_addr2},  m_n % 4);
      check("wrapped8",   {31'd0, wrapped8},   {31'd0, m_n >= 256});
      check("wrapped2",   {31'd0, wrapped2},   {31'd0, m_n >= 4});
      check("words8",     {16'd0, words8},     (m_n > 65535) ? 65535 : m_n);
      check("busy8",      {31'd0, busy8},      {31'd0, m_run || m_drain});
      check("busy2",      {31'd0, busy2},      {31'd0, m_run || m_drain});
      check("done8",      {31'd0, done8},      {31'd0, m_drain && q.size() == 0});
      check("done2",      {31'd0, done2},      {31'd0, m_drain && q.size() == 0});
      check("err8",       {31'd0, err8},       {31'd0, m_err});
      check("err_cnt8",   {24'd0, err_cnt8},   m_errs);
      check("err_cnt2",   {24'd0, err_cnt2},   m_errs);
   end

   // Write logs and done counter for the literal end-of-session checks.
   logic [7:0]  log_addr8[$];
   logic [31:0] log_data8[$];
   logic [1:0]  log_addr2[$];
   int          done_cnt2 = 0;

   always @(negedge clk) begin
      if (rst && mem_we8 && mem_ready) begin
         log_addr8.push_back(mem_addr8);
         log_data8.push_back(mem_wdata8);
      end
      if (rst && mem_we2 && mem_ready) log_addr2.push_back(mem_addr2);
      if (rst && done2) done_cnt2++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send(input tuple_t t);
      int n = 0;
      cur = t;
      in_valid = 1'b1;
      while (!(m_run && q.size() < DEPTH) && n < 20) begin tick(); n++; end
      check("send_timeout", {31'd0, n < 20}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((m_run || m_drain) && n < 30) begin tick(); n++; end
      check("drain_timeout", {31'd0, n < 30}, 32'd1);
   endtask

   function automatic tuple_t mk(input logic [3:0] cond, input logic [1:0] typ,
                                 input logic imm_en, input logic set, input logic [3:0] op,
                                 input logic [4:0] rd, input logic [4:0] rh,
                                 input logic [4:0] ro, input logic [31:0] imm);
      tuple_t t;
      t.cond = cond; t.typ = typ; t.imm_en = imm_en; t.set = set; t.op = op;
      t.rd = rd; t.rh = rh; t.ro = ro; t.imm = imm;
      return t;
   endfunction

   initial begin
      tuple_t t_reg, t_imm, t_big, t_neg;
      tuple_t bp[6];
      logic [7:0] exp_a8[4];
      logic [31:0] exp_d8[4];
      logic [1:0] exp_a2[5];

      start = 0; finish = 0; in_valid = 0; mem_ready = 0;
      cur = '0;
      t_reg = mk(4'hE, 2'd0, 1'b0, 1'b1, 4'd4, 5'd1, 5'd2, 5'd3, 32'd0);
      t_imm = mk(4'h0, 2'd1, 1'b1, 1'b0, 4'd1, 5'd5, 5'd0, 5'd7, 32'hFFFF_FFFF);
      t_big = mk(4'h0, 2'd1, 1'b1, 1'b0, 4'd1, 5'd5, 5'd0, 5'd0, 32'd512);
      t_neg = mk(4'h0, 2'd1, 1'b1, 1'b0, 4'd1, 5'd5, 5'd0, 5'd0, 32'hFFFF_FE00);
      for (int i = 0; i < 6; i++)
         bp[i] = mk(4'(i + 1), 2'd0, 1'b0, 1'b0, 4'd0, 5'(i + 1), 5'd0, 5'd0, 32'd0);

      // Pin the model against hand-computed encodings.
      check("model_reg_word", model_word(t_reg), 32'hE140_8860);
      check("model_imm_word", model_word(t_imm), 32'h0612_83FF);
      check("model_neg_word", model_word(t_neg), 32'h0612_8200);
      check("model_rej_512",  {31'd0, model_in_range(t_big)}, 32'd0);
      check("model_ok_m512",  {31'd0, model_in_range(t_neg)}, 32'd1);

      #1 rst = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", {31'd0, in_ready8}, 32'd0);
      check("rst_mem_we",   {31'd0, mem_we2},   32'd0);
      check("rst_addr",     {24'd0, mem_addr8}, 32'd0);
      check("rst_wdata",    mem_wdata8,         32'd0);
      rst = 1'b1;
      tick();

      // finish in IDLE is ignored; block waits for start.
      finish = 1'b1; tick(); finish = 1'b0; tick();
      check("idle_finish_busy", {31'd0, busy8},     32'd0);
      check("await_start",      {31'd0, in_ready8}, 32'd0);

      // Session 1: register/immediate encodings and range reject.
      mem_ready = 1'b1;
      pulse_start();
      send(t_reg);
      check("reg_we",    {31'd0, mem_we8}, 32'd1);
      check("reg_addr",  {24'd0, mem_addr8}, 32'd0);
      check("reg_wdata", mem_wdata8, 32'hE140_8860);
      tick();
      check("reg_words", {16'd0, words8}, 32'd1);
      send(t_imm);
      check("imm_wdata", mem_wdata8, 32'h0612_83FF);
      send(t_big);
      check("rej_err",     {31'd0, err8},     32'd1);
      check("rej_err_cnt", {24'd0, err_cnt8}, 32'd1);
      check("rej_no_we",   {31'd0, mem_we8},  32'd0);
      send(t_neg);
      check("neg_low10", {22'd0, mem_wdata8[9:0]}, 32'h200);
      finish = 1'b1; tick(); finish = 1'b0;
      wait_idle();

      // Session 2: backpressure with six tuples; start mid-RUN is ignored.
      mem_ready = 1'b0;
      pulse_start();
      check("start_clears_err_cnt", {24'd0, err_cnt8}, 32'd0);
      log_addr8.delete(); log_data8.delete();
      for (int i = 0; i < 4; i++) send(bp[i]);
      cur = bp[4]; in_valid = 1'b1; start = 1'b1; tick(); start = 1'b0;
      repeat (4) begin
         check("bp_in_ready", {31'd0, in_ready8}, 32'd0);
         check("bp_addr",     {24'd0, mem_addr8}, 32'd0);
         check("bp_head",     mem_wdata8, 32'h1000_8000);
         tick();
      end
      mem_ready = 1'b1;
      send(bp[4]);
      send(bp[5]);
      finish = 1'b1; tick(); finish = 1'b0;
      wait_idle();
      exp_a8 = '{8'd0, 8'd1, 8'd2, 8'd3};
      exp_d8 = '{32'h1000_8000, 32'h2001_0000, 32'h3001_8000, 32'h4002_0000};
      check("bp_log_len", log_addr8.size(), 6);
      for (int i = 0; i < 4 && i < log_addr8.size(); i++) begin
         check("bp_log_addr", {24'd0, log_addr8[i]}, {24'd0, exp_a8[i]});
         check("bp_log_data", log_data8[i], exp_d8[i]);
      end

      // Session 3: address wrap on the 2-bit instance, finish alongside last accept.
      log_addr2.delete();
      done_cnt2 = 0;
      pulse_start();
      check("start_clears_wrapped", {31'd0, wrapped2}, 32'd0);
      for (int i = 0; i < 4; i++) send(bp[i]);
      finish = 1'b1;
      send(bp[4]);
      finish = 1'b0;
      wait_idle();
      tick();
      exp_a2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      check("wrap_log_len", log_addr2.size(), 5);
      for (int i = 0; i < 5 && i < log_addr2.size(); i++)
         check("wrap_log_addr", {30'd0, log_addr2[i]}, {30'd0, exp_a2[i]});
      check("wrap_flag",  {31'd0, wrapped2}, 32'd1);
      check("wrap_done",  done_cnt2, 1);
      check("wrap_busy",  {31'd0, busy2}, 32'd0);
      check("wrap_words", {16'd0, words2}, 32'd5);

      // Session 4: reset with three buffered words.
      mem_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 3; i++) send(bp[i]);
      rst = 1'b0;
      #1;
      check("mid_rst_we8", {31'd0, mem_we8}, 32'd0);
      check("mid_rst_we2", {31'd0, mem_we2}, 32'd0);
      tick();
      rst = 1'b1;
      mem_ready = 1'b1;
      repeat (3) begin
         tick();
         check("post_rst_ready", {31'd0, in_ready8}, 32'd0);
         check("post_rst_busy",  {31'd0, busy8},     32'd0);
         check("post_rst_we",    {31'd0, mem_we8},   32'd0);
      end
      pulse_start();
      check("restart_ready", {31'd0, in_ready8}, 32'd1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
